// File: rtl/stream_pool2x2.sv
// stream_pool2x2: streaming 2x2 stride-2 max/average pooling engine.
// Even-row pair results wait in a half-width line buffer for the odd row.
module stream_pool2x2 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = $clog2(IMG_H);
    localparam int PW = DATA_W + 1;
    localparam int SW = DATA_W + 2;
    localparam int LD = IMG_W / 2;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [CW-1:0]     ecol;
    logic [RW-1:0]     row;
    logic [RW-1:0]     erow;
    logic              mode_q;
    logic              emode;
    logic              accept;
    logic              first;
    logic [DATA_W-1:0] hold;
    logic [PW-1:0]     linebuf [LD];
    logic [PW-1:0]     lb_rd;
    logic [PW-1:0]     px_e;
    logic [PW-1:0]     hd_e;
    logic [PW-1:0]     pair;
    logic [SW-1:0]     sum;
    logic [DATA_W-1:0] result;

    function automatic logic [PW-1:0] ext(input logic [DATA_W-1:0] x);
        return {SIGNED & x[DATA_W-1], x};
    endfunction

    // Flipping the sign bit turns a signed compare into an unsigned one.
    function automatic logic gt(input logic [PW-1:0] a,
                                input logic [PW-1:0] b);
        return {a[PW-1] ^ SIGNED, a[PW-2:0]} >
               {b[PW-1] ^ SIGNED, b[PW-2:0]};
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = in_sof || (row == '0 && col == '0);
    assign ecol     = in_sof ? '0 : col;
    assign erow     = in_sof ? '0 : row;
    assign emode    = first ? mode : mode_q;
    assign lb_rd    = linebuf[ecol[CW-1:1]];

    always_comb begin
        px_e = ext(in_data);
        hd_e = ext(hold);
        if (emode) pair = hd_e + px_e;
        else       pair = gt(px_e, hd_e) ? px_e : hd_e;
        sum = {pair[PW-1] & SIGNED, pair}
            + {lb_rd[PW-1] & SIGNED, lb_rd};
        if (emode) result = sum[SW-1:2];
        else       result = gt(pair, lb_rd) ? pair[DATA_W-1:0]
                                            : lb_rd[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 1'b0;
            hold   <= '0;
        end else if (accept) begin
            mode_q <= emode;
            if (!ecol[0]) hold <= in_data;
            if (ecol == COL_MAX) begin
                col <= '0;
                row <= (erow == ROW_MAX) ? '0 : erow + 1'b1;
            end else begin
                col <= ecol + 1'b1;
                row <= erow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && ecol[0] && !erow[0])
            linebuf[ecol[CW-1:1]] <= pair;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept && ecol[0] && erow[0]) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= (ecol == COL_MAX) && (erow == ROW_MAX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_pool2x2.sv
// tb_stream_pool2x2: unsigned and signed 4x4 pooling engines fed
// one shared stream, checked against an arithmetic window model.
module tb_stream_pool2x2;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       ir0, ir1, ov0, ov1, ol0, ol1;
    logic [7:0] od0, od1;

    int tests = 0;
    int fails = 0;
    bit rand_valid = 1'b0;
    bit rand_ready = 1'b0;
    logic [8:0] got0[$];
    logic [8:0] got1[$];
    logic [7:0] frm [N];

    always #5 clk = ~clk;

    stream_pool2x2 #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .in_sof(in_sof), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_last(ol0));

    stream_pool2x2 #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_sof(in_sof), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_last(ol1));

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (ov0 && out_ready) got0.push_back({ol0, od0});
        if (ov1 && out_ready) got1.push_back({ol1, od1});
    end

    function automatic logic [7:0] pool4(logic [7:0] a, logic [7:0] b,
                                         logic [7:0] c, logic [7:0] d,
                                         bit m, bit sg);
        logic [7:0] px[4];
        int v[4];
        int r;
        int s;
        px = '{a, b, c, d};
        foreach (px[k]) v[k] = sg ? int'($signed(px[k])) : int'(px[k]);
        if (m) begin
            s = v[0] + v[1] + v[2] + v[3];
            r = (s >= 0) ? s / 4 : -((3 - s) / 4);
        end else begin
            r = v[0];
            foreach (v[k]) if (v[k] > r) r = v[k];
        end
        return r[7:0];
    endfunction

    function automatic logic [8:0] exp_win(int w, bit m, bit sg);
        int b;
        b = (w / 2) * 2 * W + (w % 2) * 2;
        return {w == 3, pool4(frm[b], frm[b+1], frm[b+W], frm[b+W+1], m, sg)};
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got0.delete();
        got1.delete();
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic sof,
                              input logic m);
        int t;
        t = 0;
        if (rand_valid) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data = d;
        in_sof = sof;
        mode = m;
        @(negedge clk);
        while (!ir0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout in_ready stuck 0, want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while ((got0.size() < n || got1.size() < n) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic o[6];
        logic e[6];
        do_reset();
        @(negedge clk);
        o = '{ov0, ol0, ir0, ov1, ol1, ir1};
        e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        foreach (o[i]) begin
            tests++;
            if (o[i] !== e[i]) begin
                fails++;
                $display("FAIL reset_flag%0d got %b want %b", i, o[i], e[i]);
            end
        end
        tests++;
        if ({od0, od1} !== 16'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0000", {od0, od1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_max_frame();
        logic [7:0] want[4] = '{8'd5, 8'd9, 8'd8, 8'd255};
        logic [8:0] e0, e1;
        do_reset();
        frm = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd9,
                8'd7, 8'd7, 8'd0, 8'd1, 8'd8, 8'd6, 8'd2, 8'd255};
        // second pass has no sof: relies on the counters wrapping to 0,0
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                send_pixel(frm[i], p == 0 && i == 0, 1'b0);
        wait_out(8);
        tests++;
        if (got0.size() != 8 || got1.size() != 8) begin
            fails++;
            $display("FAIL max_count got %0d/%0d want 8", got0.size(), got1.size());
        end
        for (int i = 0; i < 8; i++) begin
            e0 = {i % 4 == 3, want[i % 4]};
            e1 = exp_win(i % 4, 1'b0, 1'b1);
            tests++;
            if (i >= got0.size() || got0[i] !== e0) begin
                fails++;
                $display("FAIL max_uns%0d got %h want %h", i,
                         i < got0.size() ? got0[i] : 9'h0, e0);
            end
            tests++;
            if (i >= got1.size() || got1[i] !== e1) begin
                fails++;
                $display("FAIL max_sgn%0d got %h want %h", i,
                         i < got1.size() ? got1[i] : 9'h0, e1);
            end
        end
    endtask

    task automatic test_avg_toggle();
        logic [7:0] want[4] = '{8'd2, 8'd5, 8'd7, 8'd64};
        logic [8:0] e0, e1;
        do_reset();
        for (int i = 0; i < N; i++)
            send_pixel(frm[i], i == 0, i == 0 ? 1'b1 : 1'(i % 2));
        wait_out(4);
        tests++;
        if (got0.size() != 4 || got1.size() != 4) begin
            fails++;
            $display("FAIL avg_count got %0d/%0d want 4", got0.size(), got1.size());
        end
        for (int i = 0; i < 4; i++) begin
            e0 = {i == 3, want[i]};
            e1 = exp_win(i, 1'b1, 1'b1);
            tests++;
            if (i >= got0.size() || got0[i] !== e0) begin
                fails++;
                $display("FAIL avg_uns%0d got %h want %h", i,
                         i < got0.size() ? got0[i] : 9'h0, e0);
            end
            tests++;
            if (i >= got1.size() || got1[i] !== e1) begin
                fails++;
                $display("FAIL avg_sgn%0d got %h want %h", i,
                         i < got1.size() ? got1[i] : 9'h0, e1);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] w0[4] = '{8'h80, 8'h40, 8'h7F, 8'h00};
        logic [7:0] w1[4];
        do_reset();
        foreach (frm[i]) frm[i] = 8'($urandom);
        frm[0] = 8'h80;
        frm[1] = 8'h7F;
        frm[W] = 8'h01;
        frm[W+1] = 8'h02;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                send_pixel(frm[i], i == 0, 1'(p));
        wait_out(8);
        w1 = '{got0.size() > 0 ? got0[0][7:0] : 8'hxx,
               got0.size() > 4 ? got0[4][7:0] : 8'hxx,
               got1.size() > 0 ? got1[0][7:0] : 8'hxx,
               got1.size() > 4 ? got1[4][7:0] : 8'hxx};
        foreach (w0[i]) begin
            tests++;
            if (w1[i] !== w0[i]) begin
                fails++;
                $display("FAIL sgn_win%0d got %h want %h", i, w1[i], w0[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= got1.size() || got1[i] !== exp_win(i % 4, 1'(i / 4), 1'b1)) begin
                fails++;
                $display("FAIL sgn_frame%0d got %h want %h", i,
                         i < got1.size() ? got1[i] : 9'h0,
                         exp_win(i % 4, 1'(i / 4), 1'b1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] e0[4];
        int bad;
        do_reset();
        foreach (frm[i]) frm[i] = 8'($urandom);
        foreach (e0[i]) e0[i] = exp_win(i, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < W + 2; i++) send_pixel(frm[i], i == 0, 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (ir0 !== 1'b0 || ov0 !== 1'b1 || od0 !== e0[0][7:0]) begin
                fails++;
                bad++;
                if (bad < 3)
                    $display("FAIL stall_c%0d got rdy=%b vld=%b d=%h want 0 1 %h",
                             c, ir0, ov0, od0, e0[0][7:0]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = W + 2; i < N; i++) send_pixel(frm[i], 1'b0, 1'b0);
        wait_out(4);
        tests++;
        if (got0.size() != 4) begin
            fails++;
            $display("FAIL bp_count got %0d want 4", got0.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got0.size() || got0[i] !== e0[i]) begin
                fails++;
                $display("FAIL bp_out%0d got %h want %h", i,
                         i < got0.size() ? got0[i] : 9'h0, e0[i]);
            end
        end
    endtask

    task automatic test_resync();
        logic [8:0] e0[5];
        logic [8:0] e1[5];
        do_reset();
        foreach (frm[i]) frm[i] = 8'($urandom);
        for (int i = 0; i < W + 2; i++) send_pixel(frm[i], i == 0, 1'b0);
        e0[0] = exp_win(0, 1'b0, 1'b0);
        e1[0] = exp_win(0, 1'b0, 1'b1);
        foreach (frm[i]) frm[i] = 8'($urandom);
        for (int w = 0; w < 4; w++) begin
            e0[w+1] = exp_win(w, 1'b1, 1'b0);
            e1[w+1] = exp_win(w, 1'b1, 1'b1);
        end
        for (int i = 0; i < N; i++) send_pixel(frm[i], i == 0, i == 0);
        wait_out(5);
        tests++;
        if (got0.size() != 5 || got1.size() != 5) begin
            fails++;
            $display("FAIL sof_count got %0d/%0d want 5", got0.size(), got1.size());
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= got0.size() || got0[i] !== e0[i] ||
                i >= got1.size() || got1[i] !== e1[i]) begin
                fails++;
                $display("FAIL sof_out%0d got %h/%h want %h/%h", i,
                         i < got0.size() ? got0[i] : 9'h0,
                         i < got1.size() ? got1[i] : 9'h0, e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        foreach (frm[i]) frm[i] = 8'($urandom);
        for (int i = 0; i < 3 * W + 1; i++) send_pixel(frm[i], i == 0, 1'b0);
        out_ready = 1'b0;
        send_pixel(frm[3 * W + 1], 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (ov0 !== 1'b1) begin
            fails++;
            $display("FAIL rst_pending got %b want 1", ov0);
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (i >= got0.size() || got0[i] !== exp_win(i, 1'b0, 1'b0)) begin
                fails++;
                $display("FAIL rst_pre%0d got %h want %h", i,
                         i < got0.size() ? got0[i] : 9'h0, exp_win(i, 1'b0, 1'b0));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            fails++;
            $display("FAIL rst_async got %b%b want 00", ov0, ov1);
        end
        do_reset();
        out_ready = 1'b1;
        foreach (frm[i]) frm[i] = 8'($urandom);
        for (int i = 0; i < N; i++) send_pixel(frm[i], 1'b0, 1'b1);
        wait_out(4);
        tests++;
        if (got0.size() != 4) begin
            fails++;
            $display("FAIL rst_count got %0d want 4", got0.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got0.size() || got0[i] !== exp_win(i, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL rst_post%0d got %h want %h", i,
                         i < got0.size() ? got0[i] : 9'h0, exp_win(i, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_random();
        bit m;
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            got0.delete();
            got1.delete();
            m = 1'($urandom_range(0, 1));
            foreach (frm[i]) frm[i] = 8'($urandom);
            for (int i = 0; i < N; i++)
                send_pixel(frm[i], i == 0 && 1'($urandom_range(0, 1)), m);
            wait_out(4);
            tests++;
            if (got0.size() != 4 || got1.size() != 4) begin
                fails++;
                $display("FAIL rnd%0d_count got %0d/%0d want 4", f,
                         got0.size(), got1.size());
            end
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (i >= got0.size() || got0[i] !== exp_win(i, m, 1'b0) ||
                    i >= got1.size() || got1[i] !== exp_win(i, m, 1'b1)) begin
                    fails++;
                    $display("FAIL rnd%0d_out%0d got %h/%h want %h/%h", f, i,
                             i < got0.size() ? got0[i] : 9'h0,
                             i < got1.size() ? got1[i] : 9'h0,
                             exp_win(i, m, 1'b0), exp_win(i, m, 1'b1));
                end
            end
        end
        rand_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_max_frame();
        test_avg_toggle();
        test_signed();
        test_backpressure();
        test_resync();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
